// File: rtl/sys_arr_pkg.sv
// Shared types and accumulator arithmetic for the output-stationary systolic tile.
package sys_arr_pkg;

  typedef enum logic [1:0] {LOAD, DRAIN, HOLD} state_t;

  // Widest accumulator the shared add helper supports.
  localparam int MAX_AW = 64;

  // Skew fill plus propagation to the far corner PE after the last beat.
  function automatic int drain_len(input int m);
    return 2 * m - 2;
  endfunction

  // Returns {overflow, result}. Operands are masked to aw bits. The sum either wraps
  // or clamps to the aw-bit range; overflow is reported in both cases.
  function automatic logic [MAX_AW:0] sat_add(input logic [MAX_AW-1:0] acc,
                                               input logic [MAX_AW-1:0] add,
                                               input int                aw,
                                               input bit                is_signed,
                                               input bit                do_sat);
    logic [MAX_AW:0] mask;
    logic [MAX_AW:0] a;
    logic [MAX_AW:0] b;
    logic [MAX_AW:0] s;
    logic [MAX_AW:0] res;
    logic            ov;
    mask = (65'd1 << aw) - 65'd1;
    a    = {1'b0, acc} & mask;
    b    = {1'b0, add} & mask;
    s    = a + b;
    if (is_signed) ov = (a[aw-1] == b[aw-1]) && (s[aw-1] != a[aw-1]);
    else           ov = s[aw];
    res = s & mask;
    if (do_sat && ov) begin
      if (!is_signed)   res = mask;
      else if (a[aw-1]) res = 65'd1 << (aw - 1);
      else              res = mask >> 1;
    end
    return {ov, res[MAX_AW-1:0]};
  endfunction

endpackage

// File: rtl/sys_arr_tile_mac_pe.sv
// One processing element: forwards a right and b down, accumulates a*b on each advance.
module mac_pe
  import sys_arr_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 32,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic [AW-1:0] acc_o,
  output logic          ovf_o
);

  logic [2*DW-1:0]   a_x;
  logic [2*DW-1:0]   b_x;
  logic [2*DW-1:0]   prod;
  logic              ext;
  logic [MAX_AW-1:0] prod64;
  logic [MAX_AW:0]   sum_full;
  logic [AW-1:0]     acc_d;
  logic              ovf_d;

  logic [DW-1:0]     a_q;
  logic [DW-1:0]     b_q;
  logic [AW-1:0]     acc_q;
  logic              ovf_q;

  // Extending both operands to 2*DW makes the low 2*DW product bits correct for either signedness.
  assign a_x    = (SIGNED != 0) ? {{DW{a_i[DW-1]}}, a_i} : {{DW{1'b0}}, a_i};
  assign b_x    = (SIGNED != 0) ? {{DW{b_i[DW-1]}}, b_i} : {{DW{1'b0}}, b_i};
  assign prod   = a_x * b_x;
  assign ext    = (SIGNED != 0) ? prod[2*DW-1] : 1'b0;
  assign prod64 = {{(MAX_AW-2*DW){ext}}, prod};

  assign sum_full = sat_add(MAX_AW'(acc_q), prod64, AW, SIGNED != 0, SAT != 0);
  assign acc_d    = sum_full[AW-1:0];
  assign ovf_d    = sum_full[MAX_AW];

  if (AW < MAX_AW) begin : g_hi
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum_full[MAX_AW-1:AW];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
      ovf_q <= ovf_q | ovf_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/sys_arr_tile.sv
// MxM output-stationary systolic matmul tile: skews unskewed k-slices, drains, holds C for the consumer.
module sys_arr_tile
  import sys_arr_pkg::*;
#(
  parameter int M      = 3,
  parameter int DW     = 8,
  parameter int AW     = 32,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              vld_in,
  output logic              rdy_in,
  input  logic [DW*M-1:0]   a_col,
  input  logic [DW*M-1:0]   b_row,
  input  logic              last_in,
  output logic              vld_out,
  input  logic              rdy_out,
  output logic [AW*M*M-1:0] c,
  output logic              ovf
);

  localparam int DRAIN_LEN = drain_len(M);
  localparam int CNT_W     = $clog2(DRAIN_LEN + 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             vld_out_q;

  logic             beat;
  logic             adv;
  logic             xfer;
  logic             load_sel;

  logic [DW-1:0]    a_feed [M];
  logic [DW-1:0]    b_feed [M];
  logic [DW-1:0]    a_lane [M];
  logic [DW-1:0]    b_lane [M];
  logic [DW-1:0]    a_h    [M][M];
  logic [DW-1:0]    b_v    [M][M];
  logic [AW-1:0]    acc    [M][M];
  logic [M*M-1:0]   ovf_pe;
  logic [M*DW-1:0]  edge_a;
  logic [M*DW-1:0]  edge_b;
  logic             unused_edge;

  assign load_sel = (state_q == LOAD);
  assign rdy_in   = load_sel && !rst;
  assign beat     = vld_in && rdy_in;
  assign adv      = beat || (state_q == DRAIN);
  assign xfer     = (state_q == HOLD) && vld_out_q && rdy_out;

  // HOLD spends its first cycle raising vld_out, so C is presented 2M cycles after the last beat.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      vld_out_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (beat && last_in) begin
            state_q <= DRAIN;
            cnt_q   <= CNT_W'(DRAIN_LEN);
          end
        end
        DRAIN: begin
          if (cnt_q == '0) state_q <= HOLD;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        HOLD: begin
          if (xfer) begin
            state_q   <= LOAD;
            vld_out_q <= 1'b0;
          end else begin
            vld_out_q <= 1'b1;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign vld_out = vld_out_q;

  // Lane i is delayed i advances; zeros enter the edges while draining.
  for (genvar i = 0; i < M; i++) begin : g_skew
    assign a_feed[i] = load_sel ? a_col[i*DW +: DW] : '0;
    assign b_feed[i] = load_sel ? b_row[i*DW +: DW] : '0;
    if (i == 0) begin : g_direct
      assign a_lane[i] = a_feed[i];
      assign b_lane[i] = b_feed[i];
    end else begin : g_shift
      logic [DW-1:0] sa_q [i];
      logic [DW-1:0] sb_q [i];
      always_ff @(posedge CLK) begin
        if (rst || xfer) begin
          for (int s = 0; s < i; s++) begin
            sa_q[s] <= '0;
            sb_q[s] <= '0;
          end
        end else if (adv) begin
          sa_q[0] <= a_feed[i];
          sb_q[0] <= b_feed[i];
          for (int s = 1; s < i; s++) begin
            sa_q[s] <= sa_q[s-1];
            sb_q[s] <= sb_q[s-1];
          end
        end
      end
      assign a_lane[i] = sa_q[i-1];
      assign b_lane[i] = sb_q[i-1];
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < M; j++) begin : g_col
      mac_pe #(
        .DW    (DW),
        .AW    (AW),
        .SIGNED(SIGNED),
        .SAT   (SAT)
      ) u_pe (
        .clk_i (CLK),
        .rst_i (rst),
        .en_i  (adv),
        .clr_i (xfer),
        .a_i   ((j == 0) ? a_lane[i] : a_h[i][(j == 0) ? 0 : j-1]),
        .b_i   ((i == 0) ? b_lane[j] : b_v[(i == 0) ? 0 : i-1][j]),
        .a_o   (a_h[i][j]),
        .b_o   (b_v[i][j]),
        .acc_o (acc[i][j]),
        .ovf_o (ovf_pe[i*M+j])
      );
      assign c[(i*M+j)*AW +: AW] = acc[i][j];
    end
    assign edge_a[i*DW +: DW] = a_h[i][M-1];
    assign edge_b[i*DW +: DW] = b_v[M-1][i];
  end

  assign unused_edge = ^{edge_a, edge_b};
  assign ovf         = |ovf_pe;

endmodule

// File: tb/tb_sys_arr_tile.sv
// Directed bench for sys_arr_tile: table of M=3 matrices plus signed and saturating corner cases.
module tb_sys_arr_tile;

  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int n;

  // M=3 unsigned wrapping instance
  logic        vld0, rdy_in0, last0, vld_out0, rdy_out0, ovf0;
  logic [23:0] a0, b0;
  logic [287:0] c0;
  sys_arr_tile #(.M(3), .DW(8), .AW(32), .SIGNED(0), .SAT(0)) dut0 (
    .CLK(CLK), .rst(rst), .vld_in(vld0), .rdy_in(rdy_in0), .a_col(a0), .b_row(b0),
    .last_in(last0), .vld_out(vld_out0), .rdy_out(rdy_out0), .c(c0), .ovf(ovf0));

  // M=2 signed instance
  logic        vld1, rdy_in1, last1, vld_out1, rdy_out1, ovf1;
  logic [15:0] a1, b1;
  logic [127:0] c1;
  sys_arr_tile #(.M(2), .DW(8), .AW(32), .SIGNED(1), .SAT(0)) dut1 (
    .CLK(CLK), .rst(rst), .vld_in(vld1), .rdy_in(rdy_in1), .a_col(a1), .b_row(b1),
    .last_in(last1), .vld_out(vld_out1), .rdy_out(rdy_out1), .c(c1), .ovf(ovf1));

  // M=2 unsigned saturating 16-bit instance
  logic        vld2, rdy_in2, last2, vld_out2, rdy_out2, ovf2;
  logic [15:0] a2, b2;
  logic [63:0] c2;
  sys_arr_tile #(.M(2), .DW(8), .AW(16), .SIGNED(0), .SAT(1)) dut2 (
    .CLK(CLK), .rst(rst), .vld_in(vld2), .rdy_in(rdy_in2), .a_col(a2), .b_row(b2),
    .last_in(last2), .vld_out(vld_out2), .rdy_out(rdy_out2), .c(c2), .ovf(ovf2));

  typedef struct {
    int a[9];    // A[i][k] at i*3+k
    int b[9];    // B[k][j] at k*3+j
    int c[9];    // expected C[i][j] at i*3+j
    int k;
    int gap;
    int hold;
  } vec_t;

  vec_t tv[6];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the transfer.
  task automatic run0(input vec_t v, input int idx);
    int lat;
    logic [287:0] snap;
    for (int k = 0; k < v.k; k++) begin
      if (v.gap != 0 && k > 0) begin
        vld0 = 1'b0;
        repeat (1 + (k % 2)) @(negedge CLK);
      end
      for (int i = 0; i < 3; i++) begin
        a0[i*8 +: 8] = 8'(v.a[i*3+k]);
        b0[i*8 +: 8] = 8'(v.b[k*3+i]);
      end
      last0 = (k == v.k - 1);
      vld0  = 1'b1;
      check($sformatf("v%0d_rdy_in_beat%0d", idx, k), rdy_in0, 1);
      @(negedge CLK);
    end
    vld0  = 1'b0;
    last0 = 1'b0;
    lat   = 0;
    while (lat < 20 && !vld_out0) begin
      @(negedge CLK);
      lat++;
    end
    check($sformatf("v%0d_latency", idx), lat, 6);
    for (int e = 0; e < 9; e++)
      check($sformatf("v%0d_c[%0d]", idx, e), c0[e*32 +: 32], v.c[e]);
    check($sformatf("v%0d_ovf", idx), ovf0, 0);
    if (v.hold > 0) begin
      snap  = c0;
      vld0  = 1'b1;
      last0 = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
        check($sformatf("v%0d_hold_vld_out", idx), vld_out0, 1);
        check($sformatf("v%0d_hold_rdy_in", idx), rdy_in0, 0);
        check($sformatf("v%0d_hold_c_stable", idx), (c0 == snap), 1);
        @(negedge CLK);
      end
      vld0  = 1'b0;
      last0 = 1'b0;
    end
    rdy_out0 = 1'b1;
    @(negedge CLK);
    rdy_out0 = 1'b0;
    check($sformatf("v%0d_vld_out_after_xfer", idx), vld_out0, 0);
    check($sformatf("v%0d_rdy_in_after_xfer", idx), rdy_in0, 1);
    check($sformatf("v%0d_c_cleared", idx), (c0 == '0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    vld0 = 0; last0 = 0; rdy_out0 = 0; a0 = '0; b0 = '0;
    vld1 = 0; last1 = 0; rdy_out1 = 0; a1 = '0; b1 = '0;
    vld2 = 0; last2 = 0; rdy_out2 = 0; a2 = '0; b2 = '0;

    tv[0].a = '{1,0,0, 0,1,0, 0,0,1};
    tv[0].b = '{1,2,3, 4,5,6, 7,8,9};
    tv[0].c = '{1,2,3, 4,5,6, 7,8,9};
    tv[0].k = 3; tv[0].gap = 0; tv[0].hold = 0;
    tv[1] = tv[0];
    tv[1].gap = 1; tv[1].hold = 5;
    tv[2].a = '{1,1,1, 1,1,1, 1,1,1};
    tv[2].b = '{1,1,1, 1,1,1, 1,1,1};
    tv[2].c = '{2,2,2, 2,2,2, 2,2,2};
    tv[2].k = 2; tv[2].gap = 0; tv[2].hold = 0;
    tv[3].a = '{9,8,7, 6,5,4, 3,2,1};
    tv[3].b = '{1,0,0, 0,1,0, 0,0,1};
    tv[3].c = '{9,8,7, 6,5,4, 3,2,1};
    tv[3].k = 3; tv[3].gap = 1; tv[3].hold = 0;
    tv[4].a = '{1,2,0, 3,4,0, 5,6,0};
    tv[4].b = '{1,0,2, 0,1,3, 0,0,0};
    tv[4].c = '{1,2,8, 3,4,18, 5,6,28};
    tv[4].k = 2; tv[4].gap = 0; tv[4].hold = 0;
    tv[5].a = '{2,0,0, 3,0,0, 4,0,0};
    tv[5].b = '{5,6,7, 0,0,0, 0,0,0};
    tv[5].c = '{10,12,14, 15,18,21, 20,24,28};
    tv[5].k = 1; tv[5].gap = 0; tv[5].hold = 0;

    @(negedge CLK);
    @(negedge CLK);
    check("rdy_in_during_rst", rdy_in0, 0);
    rst = 1'b0;
    @(negedge CLK);
    check("reset_vld_out", vld_out0, 0);
    check("reset_ovf", ovf0, 0);
    check("reset_c", (c0 == '0), 1);
    check("reset_rdy_in", rdy_in0, 1);

    for (int t = 0; t < 6; t++) run0(tv[t], t);

    // Reset in the middle of a load discards the partial sums and skew contents.
    a0 = 24'h010101; b0 = 24'h010101; last0 = 1'b0; vld0 = 1'b1;
    repeat (2) @(negedge CLK);
    vld0 = 1'b0;
    rst  = 1'b1;
    #1;
    check("rst_mid_rdy_in", rdy_in0, 0);
    @(negedge CLK);
    rst = 1'b0;
    #1;
    check("rst_mid_c", (c0 == '0), 1);
    check("rst_mid_vld_out", vld_out0, 0);
    check("rst_mid_rdy_in_after", rdy_in0, 1);
    run0(tv[0], 6);

    // Signed M=2: every product (-128)*(-128) accumulated three times.
    a1 = 16'h8080; b1 = 16'h8080;
    for (int k = 0; k < 3; k++) begin
      last1 = (k == 2);
      vld1  = 1'b1;
      @(negedge CLK);
    end
    vld1 = 1'b0; last1 = 1'b0;
    n = 0;
    while (n < 20 && !vld_out1) begin
      @(negedge CLK);
      n++;
    end
    check("signed_latency", n, 4);
    for (int e = 0; e < 4; e++) check($sformatf("signed_c[%0d]", e), c1[e*32 +: 32], 49152);
    check("signed_ovf", ovf1, 0);
    rdy_out1 = 1'b1;
    @(negedge CLK);
    rdy_out1 = 1'b0;
    check("signed_vld_out_after_xfer", vld_out1, 0);

    // Saturating 16-bit: 2*255*255 exceeds 0xFFFF.
    a2 = 16'hFFFF; b2 = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      last2 = (k == 1);
      vld2  = 1'b1;
      @(negedge CLK);
    end
    vld2 = 1'b0; last2 = 1'b0;
    n = 0;
    while (n < 20 && !vld_out2) begin
      @(negedge CLK);
      n++;
    end
    check("sat_latency", n, 4);
    for (int e = 0; e < 4; e++) check($sformatf("sat_c[%0d]", e), c2[e*16 +: 16], 16'hFFFF);
    check("sat_ovf", ovf2, 1);
    rdy_out2 = 1'b1;
    @(negedge CLK);
    rdy_out2 = 1'b0;
    check("sat_ovf_cleared", ovf2, 0);
    check("sat_c_cleared", (c2 == '0), 1);
    check("sat_vld_out_after_xfer", vld_out2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
